// File: rtl/ifetch_pf_pkg.sv
// ifetch_pf_pkg: shared types and constants for the bexkat1 prefetching fetch unit
package ifetch_pf_pkg;
    typedef enum logic [2:0] {S_RESET, S_FETCH, S_FETCH2, S_DRAIN, S_FAULT, S_HALT} ifetch_state_t;
    localparam int IFETCH_INSN_LONG_BIT = 0;
    localparam int IFETCH_ENTRY_W = 33;
endpackage

// File: rtl/ifetch_pf_fifo.sv
// ifetch_pf_fifo: show-ahead FIFO with occupancy count and synchronous flush
module ifetch_pf_fifo #(
    parameter int DWIDTH = 33,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic [AWIDTH:0]   count
);
    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [AWIDTH:0] wr_ptr, rd_ptr;
    logic full;
    assign count = wr_ptr - rd_ptr;
    assign empty = count == '0;
    assign full = count[AWIDTH];
    assign dout = mem[rd_ptr[AWIDTH-1:0]];
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= (push && !full) ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= (pop && !empty) ? rd_ptr + 1'b1 : rd_ptr;
        end
    // Stale writes on flush land in a slot the reset pointers will overwrite.
    always_ff @(posedge clk_i)
        if (push && !full) mem[wr_ptr[AWIDTH-1:0]] <= din;
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
endmodule

// File: rtl/ifetch_pf.sv
// ifetch_pf: prefetching instruction fetch with credit-limited Wishbone reads,
// 32/64-bit instruction assembly, redirect drain and bus-error faults
module ifetch_pf
    import ifetch_pf_pkg::*;
#(
    parameter int          FIFO_AWIDTH     = 4,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_VECTOR    = 32'hfffffff8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_set,
    input  logic [31:0] pc_in,
    input  logic        halt,
    input  logic        stall_i,
    output logic [63:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic        fault,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic        bus_stall_i
);
    localparam int CW = FIFO_AWIDTH + 1;
    localparam int DEPTH = 1 << FIFO_AWIDTH;
    typedef logic [CW-1:0] cnt_t;
    ifetch_state_t state, next_state;
    cnt_t outstanding, outstanding_next, count;
    logic [IFETCH_ENTRY_W-1:0] head;
    logic [31:0] fetch_pc, low;
    logic empty, stop, redirect, in_fetch, issue, retire, push, pop;
    assign stop = halt || state == S_HALT;
    assign redirect = pc_set && !stop;
    assign in_fetch = state == S_FETCH || state == S_FETCH2;
    assign issue = bus_stb_o && !bus_stall_i;
    assign retire = (bus_ack_i || bus_err_i) && outstanding != '0;
    assign push = retire && in_fetch && !redirect && !stop;
    assign pop = in_fetch && !stall_i && !redirect && !stop && !empty;
    assign outstanding_next = outstanding + cnt_t'(issue) - cnt_t'(retire);
    assign bus_sel_o = 4'hf;
    assign bus_we_o = 1'b0;
    ifetch_pf_fifo #(.DWIDTH(IFETCH_ENTRY_W), .AWIDTH(FIFO_AWIDTH)) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .flush (!rst_ni || pc_set),
        .push  (push),
        .pop   (pop),
        .din   ({bus_err_i, bus_dat_i}),
        .dout  (head),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= S_RESET;
        else state <= next_state;
    always_comb begin
        next_state = state;
        if (stop) next_state = S_HALT;
        else if (redirect) next_state = outstanding_next != '0 ? S_DRAIN : S_FETCH;
        else if (state == S_RESET) next_state = S_FETCH;
        else if (state == S_DRAIN) next_state = outstanding_next == '0 ? S_FETCH : S_DRAIN;
        else if (pop) next_state = head[32] ? S_FAULT : state == S_FETCH2 ? S_FETCH :
                                   head[IFETCH_INSN_LONG_BIT] ? S_FETCH2 : S_FETCH;
    end
    // Credit counts both buffered words and reads still in flight, so every ack has a slot.
    always_comb begin
        bus_stb_o = in_fetch && !redirect && !stop && outstanding < cnt_t'(MAX_OUTSTANDING) &&
                    ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
        bus_cyc_o = bus_stb_o || outstanding != '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            outstanding <= '0;
            bus_adr_o <= RESET_VECTOR;
        end else begin
            outstanding <= outstanding_next;
            bus_adr_o <= redirect ? pc_in : issue ? bus_adr_o + 32'd4 : bus_adr_o;
        end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            ir <= '0;
            ir_valid <= 1'b0;
            pc <= RESET_VECTOR;
            fault <= 1'b0;
            fetch_pc <= RESET_VECTOR;
            low <= '0;
        end else if (stop) begin
            ir_valid <= 1'b0;
        end else if (redirect) begin
            ir_valid <= 1'b0;
            fault <= 1'b0;
            fetch_pc <= pc_in;
        end else if (in_fetch && !stall_i) begin
            if (empty) begin
                ir <= '0;
                ir_valid <= 1'b0;
            end else if (head[32]) begin
                ir_valid <= 1'b0;
                fault <= 1'b1;
                pc <= fetch_pc;
            end else if (state == S_FETCH2) begin
                ir <= {head[31:0], low};
                ir_valid <= 1'b1;
                pc <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd8;
            end else if (head[IFETCH_INSN_LONG_BIT]) begin
                low <= head[31:0];
                ir_valid <= 1'b0;
            end else begin
                ir <= {32'h0, head[31:0]};
                ir_valid <= 1'b1;
                pc <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
endmodule

// File: tb/tb_ifetch_pf.sv
// tb_ifetch_pf: scoreboard bench for ifetch_pf against a pipelined Wishbone memory model
module tb_ifetch_pf;
    localparam logic [31:0] RV = 32'hfffffff8;
    typedef struct packed {logic [31:0] pc; logic [63:0] ir;} exp_t;
    typedef struct {logic [31:0] adr; int due;} req_t;
    logic clk_i = 1'b0, rst_ni = 1'b0, pc_set = 1'b0, halt = 1'b0, stall_i = 1'b0;
    logic [31:0] pc_in = '0;
    logic [63:0] ir;
    logic ir_valid, fault, bus_cyc_o, bus_stb_o, bus_we_o;
    logic [31:0] pc, bus_adr_o;
    logic [3:0] bus_sel_o;
    logic [31:0] bus_dat_i = '0;
    logic bus_ack_i = 1'b0, bus_err_i = 1'b0, bus_stall_i = 1'b0;
    int n_checks = 0, n_errors = 0;
    exp_t sb[$];
    exp_t e_mon;
    req_t pend[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] err_adr = 32'h1;
    int lat = 1, cyc_n = 0, n_issued = 0, n_acks = 0;

    ifetch_pf #(.FIFO_AWIDTH(4), .MAX_OUTSTANDING(4), .RESET_VECTOR(RV)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pc_set(pc_set), .pc_in(pc_in), .halt(halt),
        .stall_i(stall_i), .ir(ir), .ir_valid(ir_valid), .pc(pc), .fault(fault),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_adr_o(bus_adr_o),
        .bus_sel_o(bus_sel_o), .bus_we_o(bus_we_o), .bus_dat_i(bus_dat_i),
        .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_stall_i(bus_stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a ^ 32'h5a5a0000;
    endfunction

    function automatic void push_short(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) sb.push_back('{a + 32'(4 * i), {32'h0, rd(a + 32'(4 * i))}});
    endfunction

    // Memory slave: decides this edge's ack from earlier requests, then records the new one.
    always @(negedge clk_i) begin
        cyc_n++;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        bus_dat_i = '0;
        if (!rst_ni) pend.delete();
        else begin
            if (pend.size() > 0 && pend[0].due <= cyc_n) begin
                bus_err_i = pend[0].adr == err_adr;
                bus_ack_i = !bus_err_i;
                bus_dat_i = rd(pend[0].adr);
                void'(pend.pop_front());
                n_acks++;
            end
            if (bus_cyc_o && bus_stb_o && !bus_stall_i) begin
                pend.push_back('{bus_adr_o, cyc_n + lat});
                n_issued++;
            end
        end
    end

    always @(negedge clk_i)
        if (rst_ni && ir_valid && !stall_i && !pc_set && !halt && sb.size() > 0) begin
            e_mon = sb.pop_front();
            check("ir", ir, e_mon.ir);
            check("pc", 64'(pc), 64'(e_mon.pc));
        end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic redirect(input logic [31:0] a);
        pc_in = a;
        pc_set = 1'b1;
        tick();
        pc_set = 1'b0;
    endtask

    task automatic wait_sb(input int bound);
        int k = 0;
        while (sb.size() > 0 && k < bound) begin
            tick();
            k++;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_state();
        check("rst_cyc", 64'(bus_cyc_o), 64'd0);
        check("rst_stb", 64'(bus_stb_o), 64'd0);
        check("rst_valid", 64'(ir_valid), 64'd0);
        check("rst_ir", ir, 64'd0);
        check("rst_pc", 64'(pc), 64'(RV));
        check("rst_adr", 64'(bus_adr_o), 64'(RV));
        check("rst_fault", 64'(fault), 64'd0);
    endtask

    initial begin
        int k, n0, a0;
        logic ok;
        mem[RV] = 32'h10;
        mem[32'h40] = 32'h21;
        mem[32'h44] = 32'hdeadbeef;
        // Reset release, first stb, latency and address wrap
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_state();
        check("rst_sel", 64'(bus_sel_o), 64'hf);
        check("rst_we", 64'(bus_we_o), 64'd0);
        sb.push_back('{RV, 64'h10});
        push_short(32'hfffffffc, 1);
        push_short(32'h0, 2);
        rst_ni = 1'b1;
        tick();
        check("first_stb", 64'(bus_stb_o), 64'd1);
        check("first_adr", 64'(bus_adr_o), 64'(RV));
        k = 1;
        while (!ir_valid && k < 20) begin
            tick();
            k++;
        end
        check("latency", 64'(k), 64'd4);
        wait_sb(50);
        // 64-bit instruction
        sb.delete();
        sb.push_back('{32'h40, 64'hdeadbeef_00000021});
        push_short(32'h48, 2);
        redirect(32'h40);
        wait_sb(50);
        // Random decode and bus stalls
        lat = 2;
        sb.delete();
        push_short(32'h1000, 30);
        redirect(32'h1000);
        repeat (60) begin
            stall_i = 1'($urandom_range(0, 1));
            bus_stall_i = $urandom_range(0, 3) == 0;
            tick();
        end
        stall_i = 1'b0;
        bus_stall_i = 1'b0;
        wait_sb(150);
        // Credit limit while decode is stalled
        lat = 1;
        sb.delete();
        push_short(32'h800, 24);
        stall_i = 1'b1;
        n0 = n_issued;
        redirect(32'h800);
        tick(40);
        check("fill_issued", 64'(n_issued - n0), 64'd16);
        check("fill_stb", 64'(bus_stb_o), 64'd0);
        check("fill_cyc", 64'(bus_cyc_o), 64'd0);
        stall_i = 1'b0;
        wait_sb(100);
        // Redirect with reads in flight drains stale acks
        lat = 3;
        sb.delete();
        redirect(32'h400);
        tick(10);
        push_short(32'h100, 8);
        a0 = n_acks;
        redirect(32'h100);
        ok = 1'b1;
        k = 0;
        while (!bus_stb_o && k < 30) begin
            if (!bus_cyc_o) ok = 1'b0;
            tick();
            k++;
        end
        check("drain_stale", 64'(n_acks - a0), 64'd3);
        check("drain_adr", 64'(bus_adr_o), 64'h100);
        check("drain_cyc", 64'(ok), 64'd1);
        wait_sb(60);
        // Bus error fault, held until redirect
        lat = 1;
        err_adr = 32'h200;
        sb.delete();
        push_short(32'h1f8, 2);
        redirect(32'h1f8);
        k = 0;
        while (!fault && k < 50) begin
            tick();
            k++;
        end
        check("fault", 64'(fault), 64'd1);
        check("fault_pc", 64'(pc), 64'h200);
        check("fault_valid", 64'(ir_valid), 64'd0);
        check("fault_sb", 64'(sb.size()), 64'd0);
        tick(5);
        check("fault_hold", 64'(fault), 64'd1);
        check("fault_stb", 64'(bus_stb_o), 64'd0);
        err_adr = 32'h1;
        push_short(32'h300, 6);
        redirect(32'h300);
        check("fault_clr", 64'(fault), 64'd0);
        wait_sb(50);
        // Halt drains in-flight reads and then stays idle
        lat = 3;
        sb.delete();
        redirect(32'h600);
        tick(10);
        halt = 1'b1;
        tick();
        check("halt_stb", 64'(bus_stb_o), 64'd0);
        check("halt_valid", 64'(ir_valid), 64'd0);
        k = 0;
        while (bus_cyc_o && k < 20) begin
            tick();
            k++;
        end
        check("halt_cycles", 64'(k), 64'd2);
        check("halt_pend", 64'(pend.size()), 64'd0);
        halt = 1'b0;
        redirect(32'h700);
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (bus_cyc_o || bus_stb_o || ir_valid) ok = 1'b0;
        end
        check("halt_sticky", 64'(ok), 64'd1);
        // Reset out of halt, then asynchronous reset in the middle of a burst
        lat = 1;
        rst_ni = 1'b0;
        #1;
        check_reset_state();
        tick();
        rst_ni = 1'b1;
        tick(8);
        check("burst_cyc", 64'(bus_cyc_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_state();
        tick(2);
        sb.push_back('{RV, 64'h10});
        push_short(32'hfffffffc, 1);
        push_short(32'h0, 2);
        rst_ni = 1'b1;
        wait_sb(50);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
